// File: rtl/fll_freq_seq.sv
// Frequency-change sequencer for one FLL: park the clock on the reference,
// write the new config word, wait for lock, then return to the FLL output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a request; bypass left as the last sequence ended
// BYP_SETTLE | bypass just selected, let the mux settle
// WR_REQ     | config write requested, waiting for ack high
// WR_RELEASE | request dropped, waiting for ack low
// WR_SETTLE  | new setting applied, lock ignored while it may still be stale
// LOCK_WAIT  | waiting for synchronised lock, bounded by LOCK_TIMEOUT
// RET_SETTLE | bypass released, let the mux settle
// DONE       | one-cycle completion pulse
module fll_freq_seq #(
    parameter logic [1:0]  CFG_ADDR      = 2'd1,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_cfg_i,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        fll_req_o,
    input  logic        fll_ack_i,
    output logic [1:0]  fll_addr_o,
    output logic [31:0] fll_wdata_o,
    output logic        fll_wrn_o,
    input  logic        fll_lock_i,
    output logic        byp_en_o
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] BYP_SETTLE = 3'd1;
    localparam logic [2:0] WR_REQ     = 3'd2;
    localparam logic [2:0] WR_RELEASE = 3'd3;
    localparam logic [2:0] WR_SETTLE  = 3'd4;
    localparam logic [2:0] LOCK_WAIT  = 3'd5;
    localparam logic [2:0] RET_SETTLE = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cfg_q, cfg_d;
    logic             err_q, err_d;
    logic             byp_q, byp_d;
    logic             lock_meta_q, lock_s_q;

    // lock comes from the FLL's own clock domain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= fll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        byp_d   = byp_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cfg_d   = req_cfg_i;
                    err_d   = 1'b0;
                    byp_d   = 1'b1;
                    state_d = BYP_SETTLE;
                end
            end
            BYP_SETTLE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == SETTLE_LAST) state_d = WR_REQ;
            end
            WR_REQ: begin
                if (fll_ack_i) state_d = WR_RELEASE;
            end
            WR_RELEASE: begin
                if (!fll_ack_i) state_d = WR_SETTLE;
            end
            WR_SETTLE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == SETTLE_LAST) state_d = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (lock_s_q) begin
                    byp_d   = 1'b0;
                    state_d = RET_SETTLE;
                end else if (cnt_q == LOCK_LAST) begin
                    // keep running on the reference clock after a failed lock
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RET_SETTLE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == SETTLE_LAST) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            err_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
            byp_q   <= byp_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign byp_en_o    = byp_q;
    assign fll_req_o   = (state_q == WR_REQ);
    assign fll_addr_o  = fll_req_o ? CFG_ADDR : 2'd0;
    assign fll_wdata_o = fll_req_o ? cfg_q : 32'd0;
    // the sequencer only ever writes
    assign fll_wrn_o   = 1'b0;

endmodule
